// File: rtl/divider_pkg.sv
// Shared types and default widths for the serial restoring divider.
// Optional feature macro: SERIAL_DIVIDER_ZERO_TRAP_EN (see serial_divider.sv).
package divider_pkg;

    // Default dividend/quotient width (accumulator register width).
    localparam int DVD_W_DEF = 17;
    // Default divisor/remainder width (switch bank width).
    localparam int DVS_W_DEF = 10;

    // Divider control states.
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_DONE
    } div_state_e;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift the next dividend bit
// into the partial remainder, subtract the divisor when it fits.
module div_step
    import divider_pkg::*;
#(
    parameter int DVS_W = DVS_W_DEF
) (
    input  logic [DVS_W-1:0] rem,
    input  logic             bit_in,
    input  logic [DVS_W-1:0] divisor,
    output logic [DVS_W-1:0] rem_next,
    output logic             q_bit
);

    logic [DVS_W:0] temp;

    // Trial subtraction; the extra top bit keeps {rem, bit} from overflowing.
    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    always_comb begin
        temp     = {rem, bit_in};
        q_bit    = (temp >= {1'b0, divisor});
        rem_next = q_bit ? DVS_W'(temp - {1'b0, divisor}) : DVS_W'(temp);
    end

endmodule

// File: rtl/serial_divider.sv
// Serial restoring divider: one quotient bit per clock, MSB first.
// Press Run_Divide (active low) in IDLE to start; the result is published
// on entry to DONE and held until the next completed operation.
// Optional feature macro: SERIAL_DIVIDER_ZERO_TRAP_EN -- when defined, a zero
// divisor seen in LOAD skips the iteration and raises Div_Zero.
module serial_divider
    import divider_pkg::*;
#(
    parameter int DVD_W = DVD_W_DEF,
    parameter int DVS_W = DVS_W_DEF
) (
    input  logic             Clk,
    input  logic             Reset_Clear,
    input  logic             Run_Divide,
    input  logic [DVD_W-1:0] Dividend,
    input  logic [DVS_W-1:0] Divisor,
    output logic [DVD_W-1:0] Quotient,
    output logic [DVS_W-1:0] Remainder,
    output logic             Busy,
    output logic             Done,
    output logic             Div_Zero
);

    localparam int               CNT_W    = (DVD_W > 1) ? $clog2(DVD_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DVD_W - 1);

    div_state_e       state_q, state_d;
    logic [DVD_W-1:0] work_q;        // dividend bits shift out, quotient bits shift in
    logic [DVS_W-1:0] dvs_q;
    logic [DVS_W-1:0] rem_q;
    logic [CNT_W-1:0] cnt_q;
    logic [DVD_W-1:0] quotient_q;
    logic [DVS_W-1:0] remainder_q;
    logic [DVS_W-1:0] rem_next;
    logic             q_bit;
    logic             last_step;
    logic             zero_trap;

    div_step #(.DVS_W(DVS_W)) u_step (
        .rem      (rem_q),
        .bit_in   (work_q[DVD_W-1]),
        .divisor  (dvs_q),
        .rem_next (rem_next),
        .q_bit    (q_bit)
    );

    assign last_step = (cnt_q == CNT_LAST);

`ifdef SERIAL_DIVIDER_ZERO_TRAP_EN
    assign zero_trap = (Divisor == '0);
`else
    assign zero_trap = 1'b0;
`endif

    // State register; reset wins over every transition.
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge Clk) begin
        if (!Reset_Clear) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: one division per press, release required to re-arm.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (!Run_Divide) state_d = ST_LOAD;
            ST_LOAD:  state_d = zero_trap ? ST_DONE : ST_SHIFT;
            ST_SHIFT: if (last_step) state_d = ST_DONE;
            ST_DONE:  if (Run_Divide) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Datapath: capture operands, iterate, publish the result on completion only.
    always_ff @(posedge Clk) begin
        if (!Reset_Clear) begin
            work_q      <= '0;
            dvs_q       <= '0;
            rem_q       <= '0;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    work_q <= Dividend;
                    dvs_q  <= Divisor;
                    rem_q  <= '0;
                    cnt_q  <= '0;
                    if (zero_trap) begin
                        quotient_q  <= '1;
                        remainder_q <= Dividend[DVS_W-1:0];
                    end
                end
                ST_SHIFT: begin
                    work_q <= {work_q[DVD_W-2:0], q_bit};
                    rem_q  <= rem_next;
                    cnt_q  <= cnt_q + 1'b1;
                    if (last_step) begin
                        quotient_q  <= {work_q[DVD_W-2:0], q_bit};
                        remainder_q <= rem_next;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SERIAL_DIVIDER_ZERO_TRAP_EN
    logic div_zero_q;

    // Divide-by-zero flag, updated with the published result.
    always_ff @(posedge Clk) begin
        if (!Reset_Clear) begin
            div_zero_q <= 1'b0;
        end else if (state_q == ST_LOAD && zero_trap) begin
            div_zero_q <= 1'b1;
        end else if (state_q == ST_SHIFT && last_step) begin
            div_zero_q <= 1'b0;
        end
    end

    assign Div_Zero = div_zero_q;
`else
    assign Div_Zero = 1'b0;
`endif

    assign Quotient  = quotient_q;
    assign Remainder = remainder_q;
    assign Busy      = (state_q == ST_LOAD) || (state_q == ST_SHIFT);
    assign Done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_serial_divider.sv
// Directed self-checking bench for serial_divider (default widths 17/10).
// Expectations for the zero-divisor case follow SERIAL_DIVIDER_ZERO_TRAP_EN.
module tb_serial_divider;

    logic        Clk = 1'b0;
    logic        Reset_Clear;
    logic        Run_Divide;
    logic [16:0] Dividend;
    logic [9:0]  Divisor;
    logic [16:0] Quotient;
    logic [9:0]  Remainder;
    logic        Busy;
    logic        Done;
    logic        Div_Zero;

    int tests_run    = 0;
    int tests_failed = 0;

    serial_divider dut (
        .Clk         (Clk),
        .Reset_Clear (Reset_Clear),
        .Run_Divide  (Run_Divide),
        .Dividend    (Dividend),
        .Divisor     (Divisor),
        .Quotient    (Quotient),
        .Remainder   (Remainder),
        .Busy        (Busy),
        .Done        (Done),
        .Div_Zero    (Div_Zero)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Run_Divide must already be low; the next edge is the press edge.
    task automatic wait_result(input string tag, input int exp_lat,
                               input logic [31:0] prev_q, input bit release_run,
                               input bit mutate);
        int n;
        bit seen;
        @(posedge Clk); #1;
        check({tag, "_busy_load"}, 32'(Busy), 32'd1);
        if (release_run) Run_Divide = 1'b1;
        n    = 0;
        seen = 1'b0;
        while (n < 40 && !seen) begin
            @(posedge Clk); #1;
            n++;
            if (Done) begin
                seen = 1'b1;
            end else begin
                if (mutate && n == 3) begin
                    Divisor  = 10'd1;
                    Dividend = 17'h1FFFF;
                end
                if (n == 5) check({tag, "_hold_q"}, 32'(Quotient), prev_q);
            end
        end
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        check({tag, "_latency"}, 32'(n), 32'(exp_lat));
    endtask

    task automatic check_idle(input string tag);
        @(posedge Clk); #1;
        check({tag, "_idle_done"}, 32'(Done), 32'd0);
        check({tag, "_idle_busy"}, 32'(Busy), 32'd0);
    endtask

    initial begin
        int rises;
        logic prev_done;
`ifdef SERIAL_DIVIDER_ZERO_TRAP_EN
        // Trap path: LOAD goes straight to DONE, so Done shows one edge after the press edge.
        localparam int  ZLAT = 1;
        localparam logic ZFLAG = 1'b1;
`else
        localparam int  ZLAT = 18;
        localparam logic ZFLAG = 1'b0;
`endif

        Reset_Clear = 1'b0;
        Run_Divide  = 1'b1;
        Dividend    = '0;
        Divisor     = '0;
        repeat (2) @(posedge Clk);
        #1;
        check("rst_q", 32'(Quotient), 32'd0);
        check("rst_r", 32'(Remainder), 32'd0);
        check("rst_busy", 32'(Busy), 32'd0);
        check("rst_done", 32'(Done), 32'd0);
        check("rst_dz", 32'(Div_Zero), 32'd0);
        Reset_Clear = 1'b1;

        // 100 / 7 = 14 r 2
        Dividend = 17'd100; Divisor = 10'd7; Run_Divide = 1'b0;
        wait_result("t1", 18, 32'd0, 1'b1, 1'b0);
        check("t1_q", 32'(Quotient), 32'd14);
        check("t1_r", 32'(Remainder), 32'd2);
        check("t1_dz", 32'(Div_Zero), 32'd0);
        check_idle("t1");

        // 131071 / 1023 = 128 r 127
        Dividend = 17'h1FFFF; Divisor = 10'h3FF; Run_Divide = 1'b0;
        wait_result("t2", 18, 32'd14, 1'b1, 1'b0);
        check("t2_q", 32'(Quotient), 32'd128);
        check("t2_r", 32'(Remainder), 32'd127);
        check_idle("t2");

        // Divide by zero: all-ones quotient, low dividend bits as remainder
        Dividend = 17'h12345; Divisor = 10'd0; Run_Divide = 1'b0;
        wait_result("t3", ZLAT, 32'd128, 1'b1, 1'b0);
        check("t3_q", 32'(Quotient), 32'h1FFFF);
        check("t3_r", 32'(Remainder), 32'h345);
        check("t3_dz", 32'(Div_Zero), 32'(ZFLAG));
        check_idle("t3");

        // Zero dividend, full latency
        Dividend = 17'd0; Divisor = 10'd9; Run_Divide = 1'b0;
        wait_result("t4", 18, 32'h1FFFF, 1'b1, 1'b0);
        check("t4_q", 32'(Quotient), 32'd0);
        check("t4_r", 32'(Remainder), 32'd0);
        check("t4_dz", 32'(Div_Zero), 32'd0);
        check_idle("t4");

        // Button held ~100 cycles: exactly one division, stays in DONE
        Dividend = 17'd12345; Divisor = 10'd1; Run_Divide = 1'b0;
        wait_result("t5", 18, 32'd0, 1'b0, 1'b0);
        rises     = 0;
        prev_done = 1'b1;
        repeat (80) begin
            @(posedge Clk); #1;
            if (Done && !prev_done) rises++;
            prev_done = Done;
        end
        check("t5_extra_rises", 32'(rises), 32'd0);
        check("t5_still_done", 32'(Done), 32'd1);
        check("t5_q", 32'(Quotient), 32'd12345);
        check("t5_r", 32'(Remainder), 32'd0);
        Run_Divide = 1'b1;
        check_idle("t5");
        check_idle("t5_norestart");

        // Reset mid-SHIFT, Run held low through release
        Dividend = 17'd100; Divisor = 10'd7; Run_Divide = 1'b0;
        @(posedge Clk); #1;
        Run_Divide = 1'b1;
        repeat (10) @(posedge Clk);
        #1;
        check("t6_mid_busy", 32'(Busy), 32'd1);
        Reset_Clear = 1'b0;
        Run_Divide  = 1'b0;
        @(posedge Clk); #1;
        check("t6_rst_busy", 32'(Busy), 32'd0);
        check("t6_rst_done", 32'(Done), 32'd0);
        check("t6_rst_q", 32'(Quotient), 32'd0);
        check("t6_rst_r", 32'(Remainder), 32'd0);
        check("t6_rst_dz", 32'(Div_Zero), 32'd0);
        Reset_Clear = 1'b1;
        Dividend = 17'd50; Divisor = 10'd5;
        wait_result("t6", 18, 32'd0, 1'b1, 1'b0);
        check("t6_q", 32'(Quotient), 32'd10);
        check("t6_r", 32'(Remainder), 32'd0);
        check_idle("t6");

        // Operands changed during SHIFT are ignored
        Dividend = 17'd100; Divisor = 10'd7; Run_Divide = 1'b0;
        wait_result("t7", 18, 32'd10, 1'b1, 1'b1);
        check("t7_q", 32'(Quotient), 32'd14);
        check("t7_r", 32'(Remainder), 32'd2);
        check_idle("t7");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
